// File: rtl/debug_vga_pkg.sv
// debug_vga_pkg: shared pixel type, default 640x480@60 timing and test-pattern colours
package debug_vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int BAR_W = 80;

    // index 0 sits at the low end: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][11:0] BAR_LUT = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

endpackage

// File: rtl/debug_vga_delay_line.sv
// debug_vga_delay_line: fixed-depth shift register with a configurable idle value
module debug_vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] sr;

    // shift one stage per clock; reset fills every stage with the idle value
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {DEPTH{RST_VAL}};
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/debug_vga_timing.sv
// debug_vga_timing: VGA raster engine; DEBUG_VGA_TEST_PATTERN_EN adds a colour-bar test mode
module debug_vga_timing
    import debug_vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int PIX_LATENCY = 2
) (
    input  logic        clk_pixel,
    input  logic        rst,
    output logic [9:0]  req_x,
    output logic [9:0]  req_y,
    output logic        req_valid,
    input  logic [11:0] pixel_in,
`ifdef DEBUG_VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       h_end, v_end;
    logic [3:0] ctl, ctl_d;
    rgb444_t    src, rgb;

    assign h_end = req_x == 10'(H_TOTAL - 1);
    assign v_end = req_y == 10'(V_TOTAL - 1);

    // raster counters park on the last pixel of the frame so the first edge out of reset lands on (0,0)
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            req_x <= 10'(H_TOTAL - 1);
            req_y <= 10'(V_TOTAL - 1);
        end else begin
            req_x <= h_end ? '0 : req_x + 10'd1;
            req_y <= h_end ? (v_end ? '0 : req_y + 10'd1) : req_y;
        end
    end

    // request-domain decode of {de, hs_n, vs_n, fs}
    always_comb begin
        req_valid = req_x < 10'(H_ACTIVE) && req_y < 10'(V_ACTIVE);
        ctl = {req_valid,
               !(req_x >= 10'(H_ACTIVE + H_FP) && req_x < 10'(H_ACTIVE + H_FP + H_SYNC)),
               !(req_y >= 10'(V_ACTIVE + V_FP) && req_y < 10'(V_ACTIVE + V_FP + V_SYNC)),
               req_x == '0 && req_y == '0};
    end

    debug_vga_delay_line #(.W(4), .DEPTH(PIX_LATENCY), .RST_VAL(4'b0110)) u_ctl (
        .clk(clk_pixel), .rst(rst), .d(ctl), .q(ctl_d)
    );

`ifdef DEBUG_VGA_TEST_PATTERN_EN
    logic [6:0] bar_cnt;
    logic [2:0] bar;
    rgb444_t    bar_d;

    // bar index restarts with each line and advances every BAR_W pixels, aligned to req_x
    always_ff @(posedge clk_pixel) begin
        if (rst || h_end) begin
            bar_cnt <= '0;
            bar     <= '0;
        end else begin
            bar_cnt <= bar_cnt == 7'(BAR_W - 1) ? '0 : bar_cnt + 7'd1;
            bar     <= bar_cnt == 7'(BAR_W - 1) ? bar + 3'd1 : bar;
        end
    end

    debug_vga_delay_line #(.W(12), .DEPTH(PIX_LATENCY), .RST_VAL(12'h000)) u_bar (
        .clk(clk_pixel), .rst(rst), .d(BAR_LUT[bar]), .q(bar_d)
    );

    assign src = test_mode ? bar_d : rgb444_t'(pixel_in);
`else
    assign src = rgb444_t'(pixel_in);
`endif

    // output stage: control and colour share one register so pins stay mutually aligned
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            {vga_de, vga_hs, vga_vs, frame_start} <= 4'b0110;
            rgb <= '0;
        end else begin
            {vga_de, vga_hs, vga_vs, frame_start} <= ctl_d;
            rgb <= ctl_d[3] ? src : '0;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;

endmodule

// File: tb/tb_debug_vga_timing.sv
// tb_debug_vga_timing: checks debug_vga_timing against an arithmetic raster model
module tb_debug_vga_timing;

    typedef struct packed {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, lat;
    } cfg_t;

    typedef struct packed {
        logic [9:0] x, y;
        logic val, de, hs, vs, fs;
        int ox;
    } exp_t;

    typedef struct {
        int e;
        logic val, de, hs, fs;
        logic [11:0] rgb;
    } vec_t;

    localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam cfg_t C1 = '{16, 2, 3, 3, 6, 1, 2, 2, 2};
    localparam cfg_t C2 = '{16, 2, 3, 3, 6, 1, 2, 2, 5};

    logic clk = 0;
    logic rst = 1;
    logic tm = 0;
    logic [11:0] pd = '0, pr = '0;
    logic [9:0] hist[8];
    logic [11:0] bars[8];
    vec_t tab[13];
    int e = -1, checks = 0, passes = 0;
    int hs_run = 0, fs_seen = 0, last_fs = 0, de_cnt = 0, vs_low = 0;

    logic [9:0] rx0, ry0, rx1, ry1, rx2, ry2;
    logic rv0, rv1, rv2, hs0, hs1, hs2, vs0, vs1, vs2, de0, de1, de2, fs0, fs1, fs2;
    logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;

    always #5 clk = ~clk;

    debug_vga_timing dut0 (
        .clk_pixel(clk), .rst(rst), .req_x(rx0), .req_y(ry0), .req_valid(rv0), .pixel_in(pd),
`ifdef DEBUG_VGA_TEST_PATTERN_EN
        .test_mode(tm),
`endif
        .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0), .vga_de(de0), .frame_start(fs0)
    );

    debug_vga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                       .V_SYNC(2), .V_BP(2), .PIX_LATENCY(2)) dut1 (
        .clk_pixel(clk), .rst(rst), .req_x(rx1), .req_y(ry1), .req_valid(rv1), .pixel_in(pr),
`ifdef DEBUG_VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1), .frame_start(fs1)
    );

    debug_vga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                       .V_SYNC(2), .V_BP(2), .PIX_LATENCY(5)) dut2 (
        .clk_pixel(clk), .rst(rst), .req_x(rx2), .req_y(ry2), .req_valid(rv2), .pixel_in(pr),
`ifdef DEBUG_VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2), .frame_start(fs2)
    );

    // e = index of the request currently on req_x/req_y (-1 while in reset); pins show request e-lat-1
    function automatic exp_t model(input cfg_t c, input int ei);
        exp_t r;
        int ht, vt, m, h, v, rh, rw;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        m = ei - c.lat - 1;
        rh = ei < 0 ? ht - 1 : ei % ht;
        rw = ei < 0 ? vt - 1 : (ei / ht) % vt;
        h = m < 0 ? -1 : m % ht;
        v = m < 0 ? -1 : (m / ht) % vt;
        r.x = 10'(rh);
        r.y = 10'(rw);
        r.val = rh < c.ha && rw < c.va;
        r.de = h >= 0 && h < c.ha && v < c.va;
        r.hs = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs);
        r.vs = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vs);
        r.fs = h == 0 && v == 0;
        r.ox = h;
        return r;
    endfunction

    task automatic cmp(input string name, input int act, input int want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s at e=%0d: got %0h, want %0h", name, e, act, want);
    endtask

    task automatic chk_dut(input string t, input exp_t x, input logic [9:0] rx, input logic [9:0] ry,
                           input logic rv, input logic [11:0] rgb, input logic hs, input logic vs,
                           input logic de, input logic fs, input logic [11:0] src);
        cmp({t, ".req_x"}, int'(rx), int'(x.x));
        cmp({t, ".req_y"}, int'(ry), int'(x.y));
        cmp({t, ".req_valid"}, int'(rv), int'(x.val));
        cmp({t, ".de"}, int'(de), int'(x.de));
        cmp({t, ".hs"}, int'(hs), int'(x.hs));
        cmp({t, ".vs"}, int'(vs), int'(x.vs));
        cmp({t, ".frame_start"}, int'(fs), int'(x.fs));
        cmp({t, ".rgb"}, int'(rgb), x.de ? int'(src) : 0);
    endtask

    task automatic tick();
        logic ra;
        exp_t x0, x1, x2;
        logic [11:0] s0;
        ra = rst;
        @(posedge clk);
        #1;
        e = ra ? -1 : e + 1;
        x0 = model(C0, e);
        x1 = model(C1, e);
        x2 = model(C2, e);
        s0 = (tm && x0.ox >= 0 && x0.ox < 640) ? bars[3'(x0.ox / 80)] : {3{x0.ox[3:0]}};
        chk_dut("d0", x0, rx0, ry0, rv0, {r0, g0, b0}, hs0, vs0, de0, fs0, s0);
        chk_dut("d1", x1, rx1, ry1, rv1, {r1, g1, b1}, hs1, vs1, de1, fs1, pr);
        chk_dut("d5", x2, rx2, ry2, rv2, {r2, g2, b2}, hs2, vs2, de2, fs2, pr);
        if (ra) begin
            hs_run = 0;
            fs_seen = 0;
        end else if (!hs0) begin
            hs_run++;
        end else if (hs_run > 0) begin
            cmp("d0.hs_width", hs_run, 96);
            hs_run = 0;
        end
        if (fs1) begin
            if (fs_seen != 0) begin
                cmp("d1.frame_len", e - last_fs, 264);
                cmp("d1.de_per_frame", de_cnt, 96);
                cmp("d1.vs_low_per_frame", vs_low, 48);
            end
            fs_seen = 1;
            last_fs = e;
            de_cnt = 0;
            vs_low = 0;
        end
        de_cnt += int'(de1);
        vs_low += int'(!vs1);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = rx0;
        pd = {3{hist[2][3:0]}};
        pr = 12'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        for (int i = 0; i < 8; i++) hist[i] = '0;
        tab[0]  = '{0,   1, 0, 1, 0, 12'h000};
        tab[1]  = '{2,   1, 0, 1, 0, 12'h000};
        tab[2]  = '{3,   1, 1, 1, 1, 12'h000};
        tab[3]  = '{4,   1, 1, 1, 0, 12'h111};
        tab[4]  = '{18,  1, 1, 1, 0, 12'hFFF};
        tab[5]  = '{642, 0, 1, 1, 0, 12'hFFF};
        tab[6]  = '{643, 0, 0, 1, 0, 12'h000};
        tab[7]  = '{658, 0, 0, 1, 0, 12'h000};
        tab[8]  = '{659, 0, 0, 0, 0, 12'h000};
        tab[9]  = '{754, 0, 0, 0, 0, 12'h000};
        tab[10] = '{755, 0, 0, 1, 0, 12'h000};
        tab[11] = '{800, 1, 0, 1, 0, 12'h000};
        tab[12] = '{803, 1, 1, 1, 0, 12'h000};

        repeat (3) tick();
        cmp("reset.req_valid", int'(rv0), 0);
        cmp("reset.vga_hs", int'(hs0), 1);
        cmp("reset.vga_de", int'(de0), 0);
        rst = 0;

        for (int i = 0; i < 13; i++) begin
            while (e < tab[i].e) tick();
            cmp("tab.req_valid", int'(rv0), int'(tab[i].val));
            cmp("tab.vga_de", int'(de0), int'(tab[i].de));
            cmp("tab.vga_hs", int'(hs0), int'(tab[i].hs));
            cmp("tab.frame_start", int'(fs0), int'(tab[i].fs));
            cmp("tab.rgb", int'({r0, g0, b0}), int'(tab[i].rgb));
        end

        while (e < 2000) tick();
        for (int k = 0; k < 1000 && hs0; k++) tick();
        cmp("midline.hs_found_low", int'(hs0), 0);
        repeat (10) tick();
        rst = 1;
        tick();
        cmp("midline.vga_hs", int'(hs0), 1);
        cmp("midline.vga_de", int'(de0), 0);
        cmp("midline.req_valid", int'(rv0), 0);
        rst = 0;
        tick();
        cmp("midline.req_x", int'(rx0), 0);
        cmp("midline.req_y", int'(ry0), 0);

`ifdef DEBUG_VGA_TEST_PATTERN_EN
        tm = 1;
`endif
        while (e < 700) begin
            tick();
            if (tm && e == 3)   cmp("bar.x0", int'({r0, g0, b0}), 'hFFF);
            if (tm && e == 82)  cmp("bar.x79", int'({r0, g0, b0}), 'hFFF);
            if (tm && e == 83)  cmp("bar.x80", int'({r0, g0, b0}), 'hFF0);
            if (tm && e == 563) cmp("bar.x560", int'({r0, g0, b0}), 'h000);
            if (tm && e == 642) cmp("bar.x639", int'({r0, g0, b0}), 'h000);
        end
        tm = 0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
